// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, immediate formats and the
// opcode-to-format mapping used by the decode stage and its immediate generator.
package decode_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_32  = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e opcode_format(input logic [6:0] opcode);
        case (opcode)
            OP_IMM, OP_IMM_32, OP_LOAD, OP_JALR: return FMT_I;
            OP_STORE:                            return FMT_S;
            OP_BRANCH:                           return FMT_B;
            OP_LUI, OP_AUIPC:                    return FMT_U;
            OP_JAL:                              return FMT_J;
            OP_OP, OP_OP_32:                     return FMT_R;
            default:                             return FMT_BAD;
        endcase
    endfunction

    // Stores and branches have no destination register.
    function automatic logic fmt_writes_rd(input fmt_e fmt);
        return (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: assembles and sign-extends the immediate
// for the given format. Only instr[31:7] carries immediate bits.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:7]     instr,
    input  fmt_e            format,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (format)
            FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
            FMT_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Single-entry decode pipeline stage: decodes one instruction, captures operands
// with writeback bypass, and holds the result under downstream backpressure.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [4:0]      RS1,
    output logic [4:0]      RS2,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic            out_illegal
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready. The stage accepts whenever its single
    // entry is empty or draining this cycle, and never while flush is asserted.
    logic            accept;
    fmt_e            fmt;
    fmt_e            imm_fmt;
    logic            illegal_d;
    logic            reg_write_d;
    logic [4:0]      rd_d;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] rs1_d;
    logic [XLEN-1:0] rs2_d;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic            hold_hit1;
    logic            hold_hit2;

    assign RS1 = instr[19:15];
    assign RS2 = instr[24:20];

    assign in_ready = (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    assign fmt         = opcode_format(instr[6:0]);
    assign illegal_d   = (fmt == FMT_BAD) || (instr[1:0] != 2'b11);
    assign reg_write_d = !illegal_d && fmt_writes_rd(fmt);
    assign rd_d        = reg_write_d ? instr[11:7] : 5'd0;
    assign imm_fmt     = illegal_d ? FMT_BAD : fmt;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr  (instr[31:7]),
        .format (imm_fmt),
        .imm    (imm_d)
    );

    // x0 always reads as zero; otherwise the in-flight writeback wins over the
    // register file, which has not been updated yet.
    always_comb begin
        rs1_d = ReadData1;
        if (RS1 == 5'd0)
            rs1_d = '0;
        else if (wb_reg_write && (wb_rd == RS1))
            rs1_d = wb_data;

        rs2_d = ReadData2;
        if (RS2 == 5'd0)
            rs2_d = '0;
        else if (wb_reg_write && (wb_rd == RS2))
            rs2_d = wb_data;
    end

    // A held entry keeps snooping writebacks so it never carries stale operands.
    assign hold_hit1 = out_valid && wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs1_idx);
    assign hold_hit2 = out_valid && wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs2_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_rs1_data  <= '0;
            out_rs2_data  <= '0;
            out_imm       <= '0;
            out_rd        <= 5'd0;
            out_reg_write <= 1'b0;
            out_opcode    <= 7'd0;
            out_funct3    <= 3'd0;
            out_funct7b5  <= 1'b0;
            out_illegal   <= 1'b0;
            rs1_idx       <= 5'd0;
            rs2_idx       <= 5'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_pc        <= pc;
            out_rs1_data  <= rs1_d;
            out_rs2_data  <= rs2_d;
            out_imm       <= imm_d;
            out_rd        <= rd_d;
            out_reg_write <= reg_write_d;
            out_opcode    <= instr[6:0];
            out_funct3    <= instr[14:12];
            out_funct7b5  <= instr[30];
            out_illegal   <= illegal_d;
            rs1_idx       <= RS1;
            rs2_idx       <= RS2;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (hold_hit1)
                out_rs1_data <= wb_data;
            if (hold_hit2)
                out_rs2_data <= wb_data;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scenario tasks with a one-entry
// expected-result queue driven by an independent decode model.
module tb_decode_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [4:0]      RS1;
    logic [4:0]      RS2;
    logic [XLEN-1:0] ReadData1;
    logic [XLEN-1:0] ReadData2;
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic            out_reg_write;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic            out_funct7b5;
    logic            out_illegal;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .pc            (pc),
        .RS1           (RS1),
        .RS2           (RS2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_rs1_data  (out_rs1_data),
        .out_rs2_data  (out_rs2_data),
        .out_imm       (out_imm),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .out_opcode    (out_opcode),
        .out_funct3    (out_funct3),
        .out_funct7b5  (out_funct7b5),
        .out_illegal   (out_illegal)
    );

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            rw;
        logic [6:0]      opcode;
        logic [2:0]      f3;
        logic            f7b5;
        logic            illegal;
    } exp_t;

    localparam int W = $bits(exp_t);

    logic [W-1:0] exp_q[$];
    bit           model_valid;
    logic [4:0]   held_rs1;
    logic [4:0]   held_rs2;
    int           n_checks;
    int           n_pass;

    // Reference decode written from the instruction-set encoding tables.
    function automatic exp_t model_entry(input logic [31:0] ins, input logic [XLEN-1:0] p,
                                         input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                                         input logic we, input logic [4:0] wrd,
                                         input logic [XLEN-1:0] wd);
        exp_t        e;
        int          s;
        int          v;
        logic [31:0] vv;
        bit          rw;
        bit          ill;
        s   = ins;
        v   = 0;
        rw  = 0;
        ill = 0;
        case (ins[6:0])
            7'h13, 7'h1B, 7'h03, 7'h67: begin v = s >>> 20; rw = 1; end
            7'h23: v = ((s >>> 25) <<< 5) | int'(ins[11:7]);
            7'h63: v = ((s >>> 31) <<< 12) | (int'(ins[7]) << 11) |
                       (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
            7'h37, 7'h17: begin v = s & 32'hFFFF_F000; rw = 1; end
            7'h6F: begin
                v = ((s >>> 31) <<< 20) | (int'(ins[19:12]) << 12) |
                    (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
                rw = 1;
            end
            7'h33, 7'h3B: begin v = 0; rw = 1; end
            default: ill = 1;
        endcase
        vv        = v;
        e.imm     = {{32{vv[31]}}, vv};
        e.rw      = rw;
        e.rd      = (rw && ins[11:7] != 5'd0) ? ins[11:7] : 5'd0;
        e.illegal = ill;
        e.pc      = p;
        e.opcode  = ins[6:0];
        e.f3      = ins[14:12];
        e.f7b5    = ins[30];
        e.rs1     = (ins[19:15] == 5'd0) ? '0 : ((we && wrd == ins[19:15]) ? wd : d1);
        e.rs2     = (ins[24:20] == 5'd0) ? '0 : ((we && wrd == ins[24:20]) ? wd : d2);
        return e;
    endfunction

    function automatic exp_t dut_entry();
        exp_t e;
        e.pc      = out_pc;
        e.rs1     = out_rs1_data;
        e.rs2     = out_rs2_data;
        e.imm     = out_imm;
        e.rd      = out_rd;
        e.rw      = out_reg_write;
        e.opcode  = out_opcode;
        e.f3      = out_funct3;
        e.f7b5    = out_funct7b5;
        e.illegal = out_illegal;
        return e;
    endfunction

    function automatic bit exp_in_ready();
        return (!model_valid || out_ready) && !flush;
    endfunction

    task automatic set_in(input bit v, input logic [31:0] ins, input logic [XLEN-1:0] p,
                          input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                          input bit we, input logic [4:0] wrd, input logic [XLEN-1:0] wd,
                          input bit ordy, input bit fl);
        in_valid     = v;
        instr        = ins;
        pc           = p;
        ReadData1    = d1;
        ReadData2    = d2;
        wb_reg_write = we;
        wb_rd        = wrd;
        wb_data      = wd;
        out_ready    = ordy;
        flush        = fl;
        #1;
    endtask

    // Advance the model across the coming edge, then clock the DUT.
    task automatic tick();
        exp_t e;
        bit   acc;
        acc = in_valid && exp_in_ready();
        if (flush) begin
            if (model_valid) void'(exp_q.pop_front());
            model_valid = 0;
        end else begin
            if (model_valid && out_ready) begin
                void'(exp_q.pop_front());
                model_valid = 0;
            end else if (model_valid && wb_reg_write && wb_rd != 5'd0) begin
                e = exp_q[0];
                if (wb_rd == held_rs1) e.rs1 = wb_data;
                if (wb_rd == held_rs2) e.rs2 = wb_data;
                exp_q[0] = e;
            end
            if (acc) begin
                exp_q.push_back(model_entry(instr, pc, ReadData1, ReadData2,
                                            wb_reg_write, wb_rd, wb_data));
                held_rs1    = instr[19:15];
                held_rs2    = instr[24:20];
                model_valid = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t zero;
        zero  = '0;
        reset = 1'b1;
        set_in(0, 32'h0, '0, '0, '0, 0, 5'd0, '0, 1, 0);
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid);
        else n_pass++;
        n_checks++;
        if (dut_entry() !== zero) $display("FAIL reset_fields got=%h exp=0", dut_entry());
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        else n_pass++;
        exp_q.delete();
        model_valid = 0;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi();
        exp_t want;
        set_in(1, 32'h00508193, 64'h1000, 64'd100, 64'd7, 0, 5'd0, '0, 1, 0);
        n_checks++;
        if (RS1 !== 5'd1 || RS2 !== 5'd5) $display("FAIL addi_rs_addr got=%0d/%0d exp=1/5", RS1, RS2);
        else n_pass++;
        n_checks++;
        if (in_ready !== exp_in_ready()) $display("FAIL addi_in_ready got=%b exp=%b", in_ready, exp_in_ready());
        else n_pass++;
        tick();
        set_in(0, 32'h0, '0, '0, '0, 0, 5'd0, '0, 1, 0);
        want = exp_q[0];
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL addi_valid got=%b exp=1", out_valid);
        else n_pass++;
        n_checks++;
        if (dut_entry() !== want) $display("FAIL addi_entry got=%h exp=%h", dut_entry(), want);
        else n_pass++;
        n_checks++;
        if (out_rs1_data !== 64'd100 || out_imm !== 64'd5 || out_rd !== 5'd3 || out_reg_write !== 1'b1)
            $display("FAIL addi_fields got=rs1 %0d imm %0d rd %0d rw %b exp=100 5 3 1",
                     out_rs1_data, out_imm, out_rd, out_reg_write);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL addi_drain got=%b exp=0", out_valid);
        else n_pass++;
    endtask

    task automatic test_store();
        exp_t want;
        set_in(1, 32'h0020B423, 64'h1004, 64'd5, 64'd33, 0, 5'd0, '0, 1, 0);
        n_checks++;
        if (RS2 !== 5'd2) $display("FAIL store_rs2_addr got=%0d exp=2", RS2);
        else n_pass++;
        tick();
        set_in(0, 32'h0, '0, '0, '0, 0, 5'd0, '0, 1, 0);
        want = exp_q[0];
        n_checks++;
        if (dut_entry() !== want) $display("FAIL store_entry got=%h exp=%h", dut_entry(), want);
        else n_pass++;
        n_checks++;
        if (out_imm !== 64'd8 || out_rs2_data !== 64'd33 || out_reg_write !== 1'b0 || out_rd !== 5'd0)
            $display("FAIL store_fields got=imm %0d rs2 %0d rw %b rd %0d exp=8 33 0 0",
                     out_imm, out_rs2_data, out_reg_write, out_rd);
        else n_pass++;
        tick();
    endtask

    task automatic test_bypass();
        exp_t want;
        set_in(1, 32'h00508193, 64'h1008, 64'd0, 64'd0, 1, 5'd1, 64'd25, 1, 0);
        tick();
        // Next instruction is accepted on the same edge the first one drains.
        set_in(1, 32'h00500193, 64'h100C, 64'd99, 64'd0, 1, 5'd0, 64'd25, 1, 0);
        want = exp_q[0];
        n_checks++;
        if (out_rs1_data !== 64'd25 || dut_entry() !== want)
            $display("FAIL bypass_wb got=%h exp=%h", dut_entry(), want);
        else n_pass++;
        tick();
        set_in(1, 32'h00508193, 64'h1010, 64'd41, 64'd0, 0, 5'd1, 64'd25, 1, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_rs1_data !== 64'd0)
            $display("FAIL bypass_x0 got=valid %b rs1 %0d exp=1 0", out_valid, out_rs1_data);
        else n_pass++;
        tick();
        set_in(0, 32'h0, '0, '0, '0, 0, 5'd0, '0, 1, 0);
        n_checks++;
        if (out_rs1_data !== 64'd41) $display("FAIL bypass_no_we got=%0d exp=41", out_rs1_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        exp_t want;
        set_in(1, 32'h00508193, 64'h2000, 64'd100, 64'd0, 0, 5'd0, '0, 1, 0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            set_in(1, 32'h00100093, 64'h3000, 64'd5, 64'd5, c == 2, 5'd1, 64'd77, 0, 0);
            want = exp_q[0];
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d got=%b exp=0", c, in_ready);
            else n_pass++;
            n_checks++;
            if (out_valid !== 1'b1 || dut_entry() !== want)
                $display("FAIL bp_hold_%0d got=%h exp=%h", c, dut_entry(), want);
            else n_pass++;
            tick();
        end
        set_in(0, 32'h0, '0, '0, '0, 0, 5'd0, '0, 1, 0);
        n_checks++;
        if (out_rs1_data !== 64'd77 || out_pc !== 64'h2000)
            $display("FAIL bp_bypass got=rs1 %0d pc %h exp=77 2000", out_rs1_data, out_pc);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL bp_release got=%b exp=0", out_valid);
        else n_pass++;
    endtask

    task automatic test_illegal();
        exp_t want;
        set_in(1, 32'h00000000, 64'h4000, 64'd11, 64'd22, 0, 5'd0, '0, 1, 0);
        tick();
        set_in(1, 32'h0050818B, 64'h4004, 64'd11, 64'd22, 0, 5'd0, '0, 1, 0);
        want = exp_q[0];
        n_checks++;
        if (out_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_imm !== '0 || out_rd !== 5'd0)
            $display("FAIL illegal_zero got=ill %b rw %b imm %h rd %0d exp=1 0 0 0",
                     out_illegal, out_reg_write, out_imm, out_rd);
        else n_pass++;
        n_checks++;
        if (dut_entry() !== want) $display("FAIL illegal_entry got=%h exp=%h", dut_entry(), want);
        else n_pass++;
        tick();
        set_in(0, 32'h0, '0, '0, '0, 0, 5'd0, '0, 1, 0);
        n_checks++;
        if (out_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_imm !== '0)
            $display("FAIL illegal_custom got=ill %b rw %b imm %h exp=1 0 0",
                     out_illegal, out_reg_write, out_imm);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        set_in(1, 32'h00508193, 64'h5000, 64'd3, 64'd0, 0, 5'd0, '0, 1, 0);
        tick();
        set_in(1, 32'h00100093, 64'h5004, 64'd3, 64'd0, 0, 5'd0, '0, 0, 0);
        tick();
        set_in(1, 32'h00100093, 64'h5008, 64'd3, 64'd0, 0, 5'd0, '0, 1, 1);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b exp=0", in_ready);
        else n_pass++;
        tick();
        set_in(0, 32'h0, '0, '0, '0, 0, 5'd0, '0, 0, 0);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_held got=%b exp=0", out_valid);
        else n_pass++;
        set_in(1, 32'h00100093, 64'h500C, 64'd3, 64'd0, 0, 5'd0, '0, 1, 1);
        tick();
        set_in(0, 32'h0, '0, '0, '0, 0, 5'd0, '0, 1, 0);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_beats_accept got=%b exp=0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        exp_t want;
        set_in(1, 32'h00508193, 64'h6000, 64'd9, 64'd0, 0, 5'd0, '0, 1, 0);
        tick();
        set_in(0, 32'h0, '0, '0, '0, 0, 5'd0, '0, 0, 0);
        tick();
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL rst_hold_pre got=%b exp=1", out_valid);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_pc !== '0 || out_rs1_data !== '0 || out_imm !== '0 || out_rd !== 5'd0)
            $display("FAIL rst_async got=valid %b pc %h rs1 %h exp=0 0 0", out_valid, out_pc, out_rs1_data);
        else n_pass++;
        exp_q.delete();
        model_valid = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(1, 32'h00500193, 64'h6004, 64'd0, 64'd0, 0, 5'd0, '0, 1, 0);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL rst_idle_ready got=%b exp=1", in_ready);
        else n_pass++;
        tick();
        set_in(0, 32'h0, '0, '0, '0, 0, 5'd0, '0, 1, 0);
        want = exp_q[0];
        n_checks++;
        if (out_valid !== 1'b1 || dut_entry() !== want)
            $display("FAIL rst_first_accept got=%h exp=%h", dut_entry(), want);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [6:0]      ops[12];
        logic [XLEN-1:0] regs[32];
        logic [31:0]     r;
        logic [31:0]     ins;
        logic [4:0]      wrd;
        exp_t            want;
        ops = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h2B};
        for (int k = 0; k < 32; k++) regs[k] = {$urandom(), $urandom()};
        for (int i = 0; i < 300; i++) begin
            r   = $urandom();
            ins = {r[31:7], ops[$urandom_range(0, 11)]};
            if ($urandom_range(0, 15) == 0) ins[1:0] = 2'b01;
            case ($urandom_range(0, 2))
                0:       wrd = ins[19:15];
                1:       wrd = held_rs1;
                default: wrd = 5'($urandom_range(0, 31));
            endcase
            set_in($urandom_range(0, 3) != 0, ins, {$urandom(), $urandom()},
                   regs[ins[19:15]], regs[ins[24:20]], $urandom_range(0, 1) == 1, wrd,
                   {$urandom(), $urandom()}, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            n_checks++;
            if (RS1 !== ins[19:15] || RS2 !== ins[24:20])
                $display("FAIL b2b_rs_addr[%0d] got=%0d/%0d exp=%0d/%0d", i, RS1, RS2, ins[19:15], ins[24:20]);
            else n_pass++;
            n_checks++;
            if (in_ready !== exp_in_ready())
                $display("FAIL b2b_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_in_ready());
            else n_pass++;
            n_checks++;
            if (out_valid !== model_valid)
                $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, out_valid, model_valid);
            else n_pass++;
            if (model_valid) begin
                want = exp_q[0];
                n_checks++;
                if (dut_entry() !== want)
                    $display("FAIL b2b_entry[%0d] got=%h exp=%h", i, dut_entry(), want);
                else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        model_valid = 0;
        held_rs1    = 5'd0;
        held_rs2    = 5'd0;
        test_reset();
        test_addi();
        test_store();
        test_bypass();
        test_backpressure();
        test_illegal();
        test_flush();
        test_reset_mid_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath and register width.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in_valid / in_ready  in / out  1  upstream handshake.
REQ-005 SHALL have ports instr  in  32 and pc  in  XLEN: the fetched instruction and its address.
REQ-006 SHALL have ports RS1 / RS2  out  5 each: register-file read addresses, driven combinationally from instr[19:15] / instr[24:20].
REQ-007 SHALL have ports ReadData1 / ReadData2  in  XLEN: register-file read data for RS1 / RS2, same cycle.
REQ-008 SHALL have ports wb_reg_write  in  1, wb_rd  in  5 and wb_data  in  XLEN: the writeback currently driving the register-file write port.
REQ-009 SHALL have port flush  in  1: synchronous kill of the held entry.
REQ-010 SHALL have ports out_valid / out_ready  out / in  1  downstream handshake.
REQ-011 SHALL have ports out_pc, out_rs1_data, out_rs2_data and out_imm  out  XLEN.
REQ-012 SHALL have ports out_rd  out  5, out_reg_write  out  1, out_opcode  out  7, out_funct3  out  3, out_funct7b5  out  1 and out_illegal  out  1.

Function
REQ-013 in_ready SHALL equal !out_valid || out_ready; an input is accepted when in_valid && in_ready.
REQ-014 On accept, all out_* fields SHALL be registered in one cycle (latency 1) and out_valid SHALL be set to 1.
REQ-015 When out_valid && out_ready with no new accept, out_valid SHALL clear; accept on the same edge SHALL replace the entry without a bubble.
REQ-016 While out_valid && !out_ready, all out_* fields SHALL hold, except as stated in REQ-018.
REQ-017 Bypass at accept: if wb_reg_write && wb_rd != 0 && wb_rd == RSn, captured rsN data SHALL be wb_data; otherwise it SHALL be ReadDataN.
REQ-018 Bypass on a held entry: while held, a matching writeback, under the same conditions as REQ-017, SHALL overwrite the stored rsN data. Stored source indices are required for this.
REQ-019 Reads of x0 SHALL capture 0 regardless of ReadData or bypass.
REQ-020 Immediate SHALL be sign-extended to XLEN by format:
- I-format: opcodes 0010011, 0011011, 0000011, 1100111.
- S-format: opcode 0100011.
- B-format: opcode 1100011, bit 0 = 0.
- U-format: opcodes 0110111, 0010111, low 12 bits = 0.
- J-format: opcode 1101111, bit 0 = 0.
- R-format: opcodes 0110011, 0111011, immediate = 0.
REQ-021 out_reg_write SHALL be 1 for R, I, U and J formats, and 0 for S and B; out_rd SHALL be forced to 0 when out_reg_write is 0 or instr[11:7] == 0.
REQ-022 An opcode not listed in REQ-020, or instr[1:0] != 2'b11, SHALL set out_illegal=1, out_reg_write=0 and out_imm=0.
REQ-023 flush SHALL clear out_valid at the next edge and take priority over an accept on the same edge; in_ready SHALL be 0 while flush is high.

Reset
REQ-024 reset SHALL immediately set out_valid=0 and clear all out_* data, rd and flag registers to 0, independent of clk.
REQ-025 Reset asserted mid-handshake SHALL discard the held entry; the first accept after deassertion SHALL behave as from idle.

Structure
REQ-026 Opcode constants, the format enumeration and XLEN default SHALL live in the shared package decode_pkg.
REQ-027 Immediate generation SHALL be one combinational sub-module, imm_gen (instr in, format in, XLEN immediate out).

Verification
REQ-028 Accept, no bypass: addi x3,x1,5 (0x00508193), ReadData1=100 -> next cycle out_valid=1, out_rs1_data=100, out_imm=5, out_rd=3, out_reg_write=1.
REQ-029 Store decode: sd x2,8(x1) (0x0020B423), ReadData2=33 -> out_imm=8, out_rs2_data=33, out_reg_write=0, out_rd=0.
REQ-030 Bypass and x0 rules:
- 0x00508193 with ReadData1=0 and wb_reg_write=1, wb_rd=1, wb_data=25 -> out_rs1_data=25.
- Repeating with wb_rd=0 and RS1=0 -> out_rs1_data=0.
REQ-031 Backpressure: out_ready=0 for 3 cycles after an accept, with writeback rd=1, data=77 in cycle 2 -> in_ready=0, fields stable except out_rs1_data=77; out_ready=1 -> out_valid clears.
REQ-032 Illegal/flush/reset:
- instr=0x00000000 -> out_illegal=1, out_reg_write=0.
- flush during a held entry -> out_valid=0 next edge.
- reset pulse mid-hold -> out_valid=0 without waiting for a clock edge.
